// File: rtl/sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sched_pkg : shared types/constants for dual_issue_scheduler      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package sched_pkg;
  localparam int c_load_lat_def = 2;
  localparam int c_stat_w       = 32;
  // Tracker rd storage width; must be >= REG_AW of the instantiating design.
  localparam int c_rd_w         = 8;

  typedef enum logic [0:0] {
    SCHED_PAIR = 1'b0,
    SCHED_HI   = 1'b1
  } sched_state_t;

  typedef struct packed {
    logic              valid;
    logic [c_rd_w-1:0] rd;
  } trk_entry_t;
endpackage
`default_nettype wire

// File: rtl/dual_issue_scheduler_load_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | load_tracker : LOAD_LAT-deep shift register of in-flight load rd |
// | with four busy lookups (two sources per slot).  Rev 1.0          |
// +-----------------------------------------------------------------+
module load_tracker
  import sched_pkg::*;
#(
  parameter int LOAD_LAT = c_load_lat_def,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [REG_AW-1:0] push_rd,
  input  logic [REG_AW-1:0] s0_rs1,
  input  logic [REG_AW-1:0] s0_rs2,
  input  logic [REG_AW-1:0] s1_rs1,
  input  logic [REG_AW-1:0] s1_rs2,
  output logic              s0_busy1,
  output logic              s0_busy2,
  output logic              s1_busy1,
  output logic              s1_busy2
);
  trk_entry_t        r_trk [LOAD_LAT];
  logic [REG_AW-1:0] w_q   [4];
  logic [3:0]        w_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LOAD_LAT; i++) r_trk[i] <= '0;
    end else begin
      // x0 is never tracked, so a load to x0 cannot cause a stall
      r_trk[0].valid <= push_valid && (push_rd != '0);
      r_trk[0].rd    <= c_rd_w'(push_rd);
      for (int i = 1; i < LOAD_LAT; i++) r_trk[i] <= r_trk[i-1];
    end
  end

  assign w_q[0] = s0_rs1;
  assign w_q[1] = s0_rs2;
  assign w_q[2] = s1_rs1;
  assign w_q[3] = s1_rs2;

  always_comb begin
    w_hit = '0;
    for (int q = 0; q < 4; q++) begin
      for (int i = 0; i < LOAD_LAT; i++) begin
        if ((w_q[q] != '0) && r_trk[i].valid && (r_trk[i].rd == c_rd_w'(w_q[q])))
          w_hit[q] = 1'b1;
      end
    end
  end

  assign s0_busy1 = w_hit[0];
  assign s0_busy2 = w_hit[1];
  assign s1_busy1 = w_hit[2];
  assign s1_busy2 = w_hit[3];
endmodule
`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dual_issue_scheduler : in-order two-lane issue control.          |
// | Optional SCHED_STATS_EN adds stat counters.  Rev 1.0             |
// +-----------------------------------------------------------------+
module dual_issue_scheduler
  import sched_pkg::*;
#(
  parameter int LOAD_LAT = c_load_lat_def,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pair_valid,
  output logic              pair_ready,
  input  logic              s1_valid,
  input  logic [REG_AW-1:0] s0_rd,
  input  logic [REG_AW-1:0] s0_rs1,
  input  logic [REG_AW-1:0] s0_rs2,
  input  logic              s0_use1,
  input  logic              s0_use2,
  input  logic              s0_regwrite,
  input  logic              s0_load,
  input  logic              s0_store,
  input  logic              s0_ctrl,
  input  logic [REG_AW-1:0] s1_rd,
  input  logic [REG_AW-1:0] s1_rs1,
  input  logic [REG_AW-1:0] s1_rs2,
  input  logic              s1_use1,
  input  logic              s1_use2,
  input  logic              s1_regwrite,
  input  logic              s1_load,
  input  logic              s1_store,
  input  logic              s1_ctrl,
  input  logic              redirect,
  output logic              lane0_valid,
  output logic              lane0_sel,
  output logic              lane1_valid
`ifdef SCHED_STATS_EN
  ,
  output logic [c_stat_w-1:0] stat_dual,
  output logic [c_stat_w-1:0] stat_stall,
  output logic [c_stat_w-1:0] stat_flush
`endif
);
  sched_state_t      r_state, w_next;
  logic              w_b01, w_b02, w_b11, w_b12;
  logic              w_hz0, w_hz1, w_s1_reads_rd0, w_coissue;
  logic              w_push_valid;
  logic [REG_AW-1:0] w_push_rd;
  logic              w_unused;

  // The single branch unit only matters when s0 is a branch; s1_ctrl needs no check.
  assign w_unused = s1_ctrl;

  load_tracker #(.LOAD_LAT(LOAD_LAT), .REG_AW(REG_AW)) u_trk (
    .clk        (clk),
    .reset      (reset),
    .push_valid (w_push_valid),
    .push_rd    (w_push_rd),
    .s0_rs1     (s0_rs1),
    .s0_rs2     (s0_rs2),
    .s1_rs1     (s1_rs1),
    .s1_rs2     (s1_rs2),
    .s0_busy1   (w_b01),
    .s0_busy2   (w_b02),
    .s1_busy1   (w_b11),
    .s1_busy2   (w_b12)
  );

  assign w_hz0 = (s0_use1 && w_b01) || (s0_use2 && w_b02);
  assign w_hz1 = (s1_use1 && w_b11) || (s1_use2 && w_b12);
  assign w_s1_reads_rd0 = (s1_use1 && (s1_rs1 == s0_rd)) || (s1_use2 && (s1_rs2 == s0_rd));
  assign w_coissue = s1_valid && !w_hz1 && !s0_ctrl
                  && !((s0_load || s0_store) && (s1_load || s1_store))
                  && !(s0_regwrite && (s0_rd != '0) && w_s1_reads_rd0)
                  && !(s0_regwrite && s1_regwrite && (s0_rd == s1_rd));

  always_ff @(posedge clk) begin
    if (reset) r_state <= SCHED_PAIR;
    else       r_state <= w_next;
  end

  always_comb begin
    lane0_valid  = 1'b0;
    lane0_sel    = 1'b0;
    lane1_valid  = 1'b0;
    pair_ready   = 1'b0;
    w_next       = r_state;
    w_push_valid = 1'b0;
    w_push_rd    = s0_rd;
    if (reset) begin
      w_next = SCHED_PAIR;
    end else if (redirect) begin
      // Flush: the held pair (and any pending s1) is discarded
      pair_ready = 1'b1;
      w_next     = SCHED_PAIR;
    end else begin
      case (r_state)
        SCHED_PAIR: begin
          if (pair_valid && !w_hz0) begin
            lane0_valid = 1'b1;
            lane1_valid = w_coissue;
            if (w_coissue || !s1_valid) pair_ready = 1'b1;
            else                        w_next     = SCHED_HI;
            if (s0_load) begin
              w_push_valid = 1'b1;
              w_push_rd    = s0_rd;
            end else if (w_coissue && s1_load) begin
              w_push_valid = 1'b1;
              w_push_rd    = s1_rd;
            end
          end
        end
        SCHED_HI: begin
          if (!w_hz1) begin
            lane0_valid  = 1'b1;
            lane0_sel    = 1'b1;
            pair_ready   = 1'b1;
            w_next       = SCHED_PAIR;
            w_push_valid = s1_load;
            w_push_rd    = s1_rd;
          end
        end
        default: w_next = SCHED_PAIR;
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  logic [c_stat_w-1:0] r_dual, r_stall, r_flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dual  <= '0;
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (lane0_valid && lane1_valid && (r_dual != '1))
        r_dual <= r_dual + c_stat_w'(1);
      if (pair_valid && !lane0_valid && !redirect && (r_stall != '1))
        r_stall <= r_stall + c_stat_w'(1);
      if (redirect && (r_flush != '1))
        r_flush <= r_flush + c_stat_w'(1);
    end
  end

  assign stat_dual  = r_dual;
  assign stat_stall = r_stall;
  assign stat_flush = r_flush;
`endif
endmodule
`default_nettype wire

// File: doc/dual_issue_scheduler.md
Name: dual_issue_scheduler

Overview:
- In-order issue scheduler for the two-lane superscalar core; sits between the paired fetch/decode stage and the two execute lanes.
- Each cycle it decides whether lane 0 only, both lanes, or neither issues.
- Arbitrates the single data-memory port and the single branch unit, blocks RAW/WAW pairs and load-use hazards, and drops held work on a taken-branch redirect.

Parameters:
- LOAD_LAT, 2, cycles after issue during which a load's rd is unavailable (1..4)
- REG_AW, 5, register-index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pair_valid  in  1  decoded pair presented; held stable until consumed
- pair_ready  out  1  pair fully consumed this cycle
- s1_valid  in  1  slot 1 holds a real instruction (0 for an odd group)
- sN_rd, sN_rs1, sN_rs2  in  REG_AW each  register indices, N=0,1
- sN_use1, sN_use2  in  1 each  rs1/rs2 actually read
- sN_regwrite  in  1  writes rd
- sN_load, sN_store  in  1 each  memory op (decoder ResultSrc/MemWrite)
- sN_ctrl  in  1  branch or jump
- redirect  in  1  taken branch/jump from execute (PCSrc)
- lane0_valid  out  1  lane 0 issues this cycle
- lane0_sel  out  1  0: lane 0 gets s0; 1: lane 0 gets s1
- lane1_valid  out  1  lane 1 issues s1 this cycle

Behaviour:
- All outputs are combinational from registered state and inputs; issue decisions are made in the same cycle, with zero latency.
- Reset: state=PAIR, tracker cleared. While reset=1: lane0_valid=0, lane1_valid=0, lane0_sel=0, pair_ready=0.
- State machine:
  - PAIR: s0 is next to issue.
  - HI: s0 has issued, s1 is pending.
- busy(r): r!=0 and r matches any valid tracker entry.
- hz(N): (sN_use1 and busy(sN_rs1)) or (sN_use2 and busy(sN_rs2)).
- PAIR, pair_valid=1, hz(0)=1: no issue, pair_ready=0.
- PAIR, hz(0)=0: lane0_valid=1, lane0_sel=0.
  - Co-issue (lane1_valid=1) only if all of the following hold:
    - s1_valid=1
    - hz(1)=0
    - s0_ctrl=0
    - not (s0 mem and s1 mem)
    - not (s0_regwrite and s0_rd!=0 and s1 reads s0_rd)
    - not (s0_regwrite and s1_regwrite and s0_rd==s1_rd)
  - Co-issue or s1_valid=0: pair_ready=1, stay in PAIR.
  - Otherwise: pair_ready=0, next state HI.
- HI: if hz(1)=0, lane0_valid=1, lane0_sel=1, pair_ready=1, next state PAIR; else wait in HI.
- Load tracker: shift register of depth LOAD_LAT holding {valid, rd}.
  - Shifts every cycle.
  - An issued load with rd!=0 enters at head. At most one per cycle, guaranteed by the memory-port rule.
  - The rd stays busy for LOAD_LAT cycles after the issue cycle.
- redirect=1 (priority over everything):
  - lane0_valid=lane1_valid=0 and pair_ready=1, so the held pair is discarded.
  - Next state PAIR.
  - Tracker keeps shifting and is not cleared, since older loads still complete.
- redirect while in HI: pending s1 is dropped.
- reset mid-operation: returns to PAIR with an empty tracker next cycle; any outstanding loads are forgotten.
- pair_valid=0 in PAIR: no issue, pair_ready=0; tracker still shifts.
- Sources of x0 never stall.

Optional Feature:
- SCHED_STATS_EN defined: adds outputs stat_dual[31:0], stat_stall[31:0], stat_flush[31:0]. These are saturating counters, cleared by reset, counting:
  - cycles with both lanes issued
  - cycles with pair_valid=1 and no lane issued (excluding redirect)
  - redirect cycles
- Not defined: the ports and counters are absent, with no other behavioural change.

Decomposition:
- Shared package sched_pkg holds:
  - state encoding (SCHED_PAIR, SCHED_HI)
  - tracker entry struct {valid, rd}
  - LOAD_LAT default
  - stats width constant
- One natural sub-module, load_tracker: the shift register plus two-source busy lookup ports for each slot.

Test Plan:
- Independent pair: s0 add x1←x2,x3; s1 add x4←x5,x6 -> lane0_valid=1, lane1_valid=1, lane0_sel=0, pair_ready=1 in the same cycle.
- RAW pair: s0 writes x5, s1 reads x5 -> cycle 0: lane0 only, pair_ready=0; cycle 1: lane0_sel=1, pair_ready=1.
- Two memory ops, s0 lw and s1 sw -> split across two cycles; the same holds when s0 is a branch (s0_ctrl=1).
- Load-use, LOAD_LAT=2: lw x7 issued at cycle 0; next pair reads x7 -> stalled cycles 1-2, issues cycle 3. With source x0 there is no stall.
- redirect asserted while in HI -> no lane valid, pair_ready=1, state PAIR next cycle; tracker entry from an earlier lw is still busy until it expires.
- reset asserted while in HI with the tracker full -> next cycle: PAIR, no busy registers; with SCHED_STATS_EN all counters read 0.
